ahb_ram_slave: RTL
==================

# ahb_ram_slave

AHB-Lite responder for the external bus: one instance sits behind one `ext_sel[i]` / `ext_rdata[i]` / `ext_ready_slv[i]` / `ext_resp[i]` group and answers the transfers that the bus controller issues on behalf of the control unit. It is a word-organised RAM with byte/halfword/word access and programmable wait states. It runs the pipelined address/data-phase protocol and returns the two-cycle ERROR response for illegal transfers. Device 0 (instruction/data RAM below 2048) is its first user.

## Interface
- `DEPTH`, 512: number of 32-bit words; must be a power of two; local byte offset is `addr[$clog2(DEPTH)+1:0]`, upper bits ignored (decoding is done upstream).
- `WAIT_STATES`, 0: number of `ready=0` cycles inserted before each OKAY data phase; 0..15.
- `clock`  in  1  system clock, all state on rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `sel`  in  1  device select from the bus controller.
- `write`  in  1  1 = write transfer (address phase).
- `addr`  in  32  byte address (address phase).
- `size`  in  `transfer_size`  0 byte, 1 halfword, 2 word; other codes illegal.
- `trans`  in  `transfer_kind`  IDLE 0, BUSY 1, NONSEQ 2, SEQ 3.
- `ready_in`  in  1  bus-wide ready (previous data phase completing).
- `wdata`  in  32  write data (data phase).
- `rdata`  out  32  read data, valid when `ready_out=1` and `resp=OKAY`.
- `ready_out`  out  1  data-phase completion.
- `resp`  out  `transfer_response`  OKAY 0, ERROR 1.
- `burst`, `prot`, `mastlock` are accepted and ignored.

## Operation
- Address phase accepted when `sel && ready_in && trans[1]`; latch `write`, local offset, `size` into a pending register.
- Accepted IDLE/BUSY (or `sel=0`) → next cycle OKAY, `ready_out=1`, no memory access.
- Illegal transfer: `size>2`; halfword with `addr[0]=1`; word with `addr[1:0]≠0`. No memory access, no write.
- States:
  - IDLE: no pending data phase; `ready_out=1`, `resp=OKAY`.
  - WAIT: counter loaded with `WAIT_STATES`, decremented each cycle; `ready_out=0`, `resp=OKAY`; goes to XFER when the counter hits 0.
  - XFER: `ready_out=1`, `resp=OKAY`; reads drive `rdata`, writes commit `wdata` on this edge.
  - ERR1: `ready_out=0`, `resp=ERROR`.
  - ERR2: `ready_out=1`, `resp=ERROR`.
- Transitions on acceptance:
  - Illegal → ERR1.
  - Legal with `WAIT_STATES=0` → XFER.
  - Legal with `WAIT_STATES>0` → WAIT.
- From XFER/ERR2/IDLE: a new acceptance in the same cycle follows the rules above; otherwise → IDLE. ERR1 → ERR2 unconditionally.
- Byte lanes are little-endian.
  - Writes: byte writes lane `offset[1:0]`; halfword writes lanes `{offset[1],0}`+1; other lanes are preserved.
  - Reads: return the full aligned word regardless of size.
- Read data is sampled from the array in the data phase. A write immediately followed by a read of the same address returns the new data.

## Timing
- Reset (async assert, sync to clock on release): state IDLE, `ready_out=1`, `resp=OKAY`, `rdata=0`, pending register and counter cleared. RAM contents are not cleared.
- Latency, address phase to `ready_out=1` with OKAY: `1+WAIT_STATES` cycles.
- ERROR: exactly 2 data-phase cycles (ERR1 then ERR2). A new address phase is never accepted during ERR1, because `ready_in` is low then.
- Back-to-back transfers at `WAIT_STATES=0` sustain one per cycle (pipelined address/data overlap).
- `rdata` holds its last value outside read XFER cycles.
- `nreset` asserted mid-WAIT or mid-ERR1: the transfer is abandoned, no write commits, and outputs return to their reset values immediately.
- `sel` deasserted while in WAIT/ERR1: the pending transfer still completes; `sel` matters only in the address phase.

## Test plan
- Reset: drive `nreset=0` mid-WAIT of a write to 0x10 → `ready_out=1`, `resp=0`, `rdata=0` at once; a later read of 0x10 returns the prior contents.
- Word write/read, `WAIT_STATES=0`: write 0xDEADBEEF to 0x04 then read 0x04 back-to-back → OKAY each cycle; read returns 0xDEADBEEF one cycle after its address phase.
- Byte/halfword merge: fill 0x08 with 0x11223344, byte-write 0xAA to 0x09, halfword-write 0xBBCC to 0x0A → word read gives 0xBBCCAA44.
- Wait states, `WAIT_STATES=3`: read 0x00 → `ready_out` low for 3 cycles, high on the 4th with data; a NONSEQ presented during the wait is accepted only on the completion cycle.
- Error: word read at 0x06, and `size=3` at 0x00 → each gives `ready_out` 0 then 1 with `resp=ERROR` both cycles; RAM is unchanged and the following legal transfer proceeds normally.
- IDLE/BUSY/unselected: `trans=1` with `sel=1`, and NONSEQ with `sel=0` → zero-wait OKAY, no RAM change, `rdata` unchanged.

Source files
------------

// File: rtl/ahb_ram_slave_if.sv
// Bus-side signal bundle for one AHB-Lite RAM responder slot.
// The slave modport is what the responder sees; master is the controller view.
interface ahb_ram_slave_if;
  logic        sel;
  logic        write;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [1:0]  trans;
  logic        ready_in;
  logic [31:0] wdata;
  logic [2:0]  burst;
  logic [3:0]  prot;
  logic        mastlock;
  logic [31:0] rdata;
  logic        ready_out;
  logic        resp;

  modport slave (
    input  sel, write, addr, size, trans, ready_in, wdata, burst, prot, mastlock,
    output rdata, ready_out, resp
  );

  modport master (
    output sel, write, addr, size, trans, ready_in, wdata, burst, prot, mastlock,
    input  rdata, ready_out, resp
  );
endinterface

// File: rtl/ahb_ram_slave.sv
// Word-organised AHB-Lite RAM responder with byte/halfword/word lanes,
// programmable wait states and the two-cycle ERROR response.
//
//   state  | meaning
//   IDLE   | no data phase pending, ready high, OKAY
//   WAIT   | legal transfer pending, wait-state down-counter running
//   XFER   | data phase completes: read drives rdata, write commits wdata
//   ERR1   | first ERROR cycle, ready low
//   ERR2   | second ERROR cycle, ready high
module ahb_ram_slave #(
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic            clock,
  input  logic            nreset,
  ahb_ram_slave_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [OW-1:0]   off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];
  logic [OW-1:0]   addr_off;
  logic [AW-1:0]   widx;
  logic [3:0]      lane_we;
  logic            accept;
  logic            illegal;
  logic            unused_bits;

  assign addr_off    = bus.addr[OW-1:0];
  assign widx        = off_q[OW-1:2];
  assign unused_bits = ^{bus.addr[31:OW], bus.burst, bus.prot, bus.mastlock};

  // New address phases are only taken while this slot is not stalling the bus
  assign accept  = bus.sel && bus.ready_in && bus.trans[1]
                   && (state_q inside {S_IDLE, S_XFER, S_ERR2});
  assign illegal = (bus.size > 3'd2)
                   || ((bus.size == 3'd1) && addr_off[0])
                   || ((bus.size == 3'd2) && (addr_off[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    off_d   = off_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_XFER;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          write_d = bus.write;
          off_d   = addr_off;
          size_d  = bus.size;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_XFER;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_comb begin
    lane_we = 4'b0000;
    if ((state_q == S_XFER) && write_q) begin
      case (size_q)
        3'd0:    lane_we[off_q[1:0]] = 1'b1;
        3'd1:    lane_we = off_q[1] ? 4'b1100 : 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // Asynchronous array read so a write committed on the previous edge is visible
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == S_XFER) && !write_q) rdata_d = mem[widx];
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      off_q   <= off_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata     = rdata_d;
  assign bus.ready_out = state_q inside {S_IDLE, S_XFER, S_ERR2};
  assign bus.resp      = state_q inside {S_ERR1, S_ERR2};
endmodule
